matrix_scan_595: RTL

- Downstream consumer of the 64-bit frame produced by the animation block (bit y*8+x = pixel row y, column x).
- Multiplexes the 8x8 dot matrix one row at a time through two daisy-chained 74HC595s.
- Each 16-bit word is {row select byte, column byte}, shifted serially MSB first, then latched and held for a programmable time.
- The frame is snapshotted once per full scan so a mid-scan frame update never tears.

---
 rtl/matrix_pkg.sv | 30 +++
 rtl/hc595_serializer.sv | 89 ++++++++
 rtl/matrix_scan_595.sv | 97 +++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the 8x8 matrix scanner driving two chained 74HC595s.
package matrix_pkg;

  localparam int unsigned MATRIX_W = 8;
  localparam int unsigned MATRIX_H = 8;
  localparam int unsigned SR_BITS  = 16;

  typedef enum logic [2:0] {
    StLoad,
    StShiftLo,
    StShiftHi,
    StLatch,
    StHold
  } scan_state_e;

  // {row select byte, column byte}; column x lands on word bit x.
  function automatic logic [SR_BITS-1:0] row_word(input logic [2:0]  row,
                                                  input logic [63:0] frame,
                                                  input logic        row_active_low,
                                                  input logic        col_active_low);
    logic [7:0] row_byte;
    logic [7:0] col_byte;
    row_byte = 8'h01 << row;
    col_byte = frame[{row, 3'b000} +: 8];
    if (row_active_low) row_byte = ~row_byte;
    if (col_active_low) col_byte = ~col_byte;
    return {row_byte, col_byte};
  endfunction

endpackage

// File: rtl/hc595_serializer.sv
// Shifts one 16-bit word MSB first into a 595 chain, then pulses RCLK.
// done is high in the last latch cycle so the caller can move on without a bubble.
module hc595_serializer
  import matrix_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SR_BITS-1:0] word,
  input  logic               start,
  output logic               sr_data,
  output logic               sr_clk,
  output logic               sr_latch,
  output logic               done
);

  localparam int unsigned CntW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] PhaseReload = CntW'(CLK_DIV - 1);

  // StLoad doubles as idle: waiting for the next word.
  scan_state_e        state_q;
  logic [CntW-1:0]    cnt_q;
  logic [3:0]         bitcnt_q;
  logic [SR_BITS-1:0] word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StLoad;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      word_q   <= '0;
      sr_data  <= 1'b0;
      sr_clk   <= 1'b0;
      sr_latch <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (start) begin
            word_q   <= word;
            bitcnt_q <= 4'd15;
            cnt_q    <= PhaseReload;
            sr_data  <= word[SR_BITS-1];
            sr_clk   <= 1'b0;
            state_q  <= StShiftLo;
          end
        end
        StShiftLo: begin
          if (cnt_q == '0) begin
            cnt_q   <= PhaseReload;
            sr_clk  <= 1'b1;
            state_q <= StShiftHi;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StShiftHi: begin
          if (cnt_q == '0) begin
            cnt_q  <= PhaseReload;
            sr_clk <= 1'b0;
            if (bitcnt_q == 4'd0) begin
              sr_latch <= 1'b1;
              state_q  <= StLatch;
            end else begin
              // Next bit goes out on the same edge SRCLK falls.
              bitcnt_q <= bitcnt_q - 4'd1;
              sr_data  <= word_q[bitcnt_q - 4'd1];
              state_q  <= StShiftLo;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StLatch: begin
          if (cnt_q == '0) begin
            sr_latch <= 1'b0;
            state_q  <= StLoad;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign done = (state_q == StLatch) && (cnt_q == '0);

endmodule

// File: rtl/matrix_scan_595.sv
// Row-multiplexed 8x8 matrix scanner: snapshots the frame at row 0, serializes one
// row word per row through the 595 chain and holds it lit for ROW_HOLD cycles.
module matrix_scan_595
  import matrix_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned ROW_HOLD       = 2000,
  parameter bit          ROW_ACTIVE_LOW = 1'b0,
  parameter bit          COL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] frame_data,
  input  logic        enable,
  output logic        sr_data,
  output logic        sr_clk,
  output logic        sr_latch,
  output logic        sr_oe_n,
  output logic [2:0]  row_idx,
  output logic        frame_start
);

  localparam int unsigned CntMax = (CLK_DIV > ROW_HOLD) ? CLK_DIV : ROW_HOLD;
  localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HoldReload = CntW'(ROW_HOLD - 1);

  // StShiftLo here spans the whole shift/latch sequence run by the serializer.
  scan_state_e        state_q;
  logic [CntW-1:0]    hold_cnt_q;
  logic [63:0]        frame_buf_q;
  logic               oe_armed_q;
  logic [63:0]        load_frame;
  logic [SR_BITS-1:0] word;
  logic               ser_start;
  logic               ser_done;

  // Row 0 takes its word straight from the frame being snapshotted this cycle.
  assign load_frame = (row_idx == 3'd0) ? frame_data : frame_buf_q;
  assign word       = row_word(row_idx, load_frame, ROW_ACTIVE_LOW, COL_ACTIVE_LOW);
  assign ser_start  = (state_q == StLoad);

  hc595_serializer #(
    .CLK_DIV (CLK_DIV)
  ) u_serializer (
    .clk      (clk),
    .rst_n    (rst_n),
    .word     (word),
    .start    (ser_start),
    .sr_data  (sr_data),
    .sr_clk   (sr_clk),
    .sr_latch (sr_latch),
    .done     (ser_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoad;
      hold_cnt_q  <= '0;
      frame_buf_q <= '0;
      oe_armed_q  <= 1'b0;
      row_idx     <= 3'd0;
      frame_start <= 1'b0;
      sr_oe_n     <= 1'b1;
    end else begin
      frame_start <= 1'b0;
      // Outputs stay dark until the 595 holds real data from the first latch.
      sr_oe_n <= (oe_armed_q || ser_done) ? ~enable : 1'b1;
      if (ser_done) oe_armed_q <= 1'b1;

      unique case (state_q)
        StLoad: begin
          if (row_idx == 3'd0) begin
            frame_buf_q <= frame_data;
            frame_start <= 1'b1;
          end
          state_q <= StShiftLo;
        end
        StShiftLo: begin
          if (ser_done) begin
            hold_cnt_q <= HoldReload;
            state_q    <= StHold;
          end
        end
        StHold: begin
          if (hold_cnt_q == '0) begin
            row_idx <= row_idx + 3'd1;
            state_q <= StLoad;
          end else begin
            hold_cnt_q <= hold_cnt_q - CntW'(1);
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule
